// File: rtl/cfa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfa_pkg
// Description : Shared constants and types for the entry-wise accumulator
//               and the downstream entry-wise mean stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cfa_pkg;

  localparam int PIX_W      = 12;  // pixel lane width
  localparam int SUM_W      = 16;  // group sum width
  localparam int MEAN_GROUP = 5;   // beats summed per group
  localparam int N_LANES    = 5;   // parallel pixel lanes

  // Group controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage : cfa_pkg
`default_nettype wire

// File: rtl/lane_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : lane_accumulator
// Description : One pixel lane: running accumulator plus a held group-sum
//               register. The final beat of a group lands directly in the
//               held register so the running sum can restart immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_accumulator
  import cfa_pkg::*;
#(
  parameter int DATA_W = cfa_pkg::PIX_W,
  parameter int SUM_W  = cfa_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  logic [DATA_W-1:0] pix,
  output logic [SUM_W-1:0]  sum
);

  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_next;

  // Zero-extended running sum including the current beat
  assign w_next = r_acc + {{(SUM_W-DATA_W){1'b0}}, pix};

  // Accumulate, hand off the completed group, or discard the partial group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sum <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (accept) begin
      if (last) begin
        r_sum <= w_next;
        r_acc <= '0;
      end else begin
        r_acc <= w_next;
      end
    end
  end

  assign sum = r_sum;

endmodule : lane_accumulator
`default_nettype wire

// File: rtl/entry_wise_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : entry_wise_accumulator
// Description : Sums five parallel pixel lanes over groups of N_SAMPLES valid
//               beats. Double-buffered: the previous group's sums stay on
//               e1..e5 while the next group accumulates. sum_valid strobes
//               for one cycle whenever e1..e5 take a new group.
// Revision    : 1.0 - initial release
// ============================================================================
module entry_wise_accumulator
  import cfa_pkg::*;
#(
  parameter int DATA_W    = cfa_pkg::PIX_W,
  parameter int SUM_W     = cfa_pkg::SUM_W,
  parameter int N_SAMPLES = cfa_pkg::MEAN_GROUP,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  input  logic [DATA_W-1:0] p4,
  input  logic [DATA_W-1:0] p5,
  output logic [SUM_W-1:0]  e1,
  output logic [SUM_W-1:0]  e2,
  output logic [SUM_W-1:0]  e3,
  output logic [SUM_W-1:0]  e4,
  output logic [SUM_W-1:0]  e5,
  output logic              sum_valid,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  // Elaboration-time parameter sanity check
  if (N_SAMPLES < 2 || CNT_W < $clog2(N_SAMPLES) ||
      SUM_W < DATA_W + $clog2(N_SAMPLES)) begin : g_param_check
    $fatal(1, "entry_wise_accumulator: illegal parameter combination");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_sum_valid;
  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_pix [N_LANES];
  logic [SUM_W-1:0]  w_sum [N_LANES];

  // clear takes priority: a beat arriving with clear is dropped
  assign w_accept = in_valid & ~clear;
  assign w_last   = w_accept & (r_beat_cnt == c_last_beat);

  assign w_pix[0] = p1;
  assign w_pix[1] = p2;
  assign w_pix[2] = p3;
  assign w_pix[3] = p4;
  assign w_pix[4] = p5;

  // Beat counter, group FSM and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (clear) begin
        r_state    <= IDLE;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_state     <= IDLE;
          r_beat_cnt  <= '0;
          r_sum_valid <= 1'b1;
        end else begin
          r_state    <= ACCUM;
          r_beat_cnt <= r_beat_cnt + c_one;
        end
      end
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    lane_accumulator #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .accept (w_accept),
      .last   (w_last),
      .pix    (w_pix[k]),
      .sum    (w_sum[k])
    );
  end

  assign e1        = w_sum[0];
  assign e2        = w_sum[1];
  assign e3        = w_sum[2];
  assign e4        = w_sum[3];
  assign e5        = w_sum[4];
  assign sum_valid = r_sum_valid;
  assign beat_cnt  = r_beat_cnt;
  assign busy      = (r_state == ACCUM);

endmodule : entry_wise_accumulator
`default_nettype wire

// File: tb/tb_entry_wise_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_entry_wise_accumulator
// Description : Directed table-driven bench for entry_wise_accumulator, plus
//               hand-written async-reset and hold sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entry_wise_accumulator;

  typedef struct {
    logic             valid;
    logic             clr;
    logic [4:0][11:0] p;
    logic [4:0][15:0] e;
    logic             sv;
    logic [2:0]       cnt;
    logic             bsy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] pv [5];
  logic [15:0] e1, e2, e3, e4, e5;
  logic        sum_valid;
  logic [2:0]  beat_cnt;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  entry_wise_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .p1        (pv[0]),
    .p2        (pv[1]),
    .p3        (pv[2]),
    .p4        (pv[3]),
    .p5        (pv[4]),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .e4        (e4),
    .e5        (e5),
    .sum_valid (sum_valid),
    .beat_cnt  (beat_cnt),
    .busy      (busy)
  );

  // Append one record: inputs, then expected e1..e5, sum_valid, beat_cnt, busy
  function automatic void add(logic v, logic c,
                              int a1, int a2, int a3, int a4, int a5,
                              int x1, int x2, int x3, int x4, int x5,
                              logic sv, int cnt, logic bsy);
    vec_t r;
    r.valid = v;  r.clr = c;
    r.p[0] = 12'(a1); r.p[1] = 12'(a2); r.p[2] = 12'(a3);
    r.p[3] = 12'(a4); r.p[4] = 12'(a5);
    r.e[0] = 16'(x1); r.e[1] = 16'(x2); r.e[2] = 16'(x3);
    r.e[3] = 16'(x4); r.e[4] = 16'(x5);
    r.sv = sv; r.cnt = 3'(cnt); r.bsy = bsy;
    tbl.push_back(r);
  endfunction

  task automatic check(string name, vec_t r);
    logic [4:0][15:0] act;
    act = {e5, e4, e3, e2, e1};
    n_vec++;
    if (act !== r.e || sum_valid !== r.sv || beat_cnt !== r.cnt || busy !== r.bsy) begin
      n_err++;
      $display("FAIL %s: got e=%0d,%0d,%0d,%0d,%0d sv=%b cnt=%0d busy=%b want e=%0d,%0d,%0d,%0d,%0d sv=%b cnt=%0d busy=%b",
               name, e1, e2, e3, e4, e5, sum_valid, beat_cnt, busy,
               r.e[0], r.e[1], r.e[2], r.e[3], r.e[4], r.sv, r.cnt, r.bsy);
    end
  endtask

  // Drive one cycle of inputs, then sample shortly after the rising edge
  task automatic step(logic v, logic c, logic [4:0][11:0] p);
    in_valid = v;
    clear    = c;
    for (int k = 0; k < 5; k++) pv[k] = p[k];
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r;
    logic [4:0][11:0] pz;
    logic [4:0][11:0] pb;
    pz = '0;
    for (int k = 0; k < 5; k++) pv[k] = '0;

    // Full-scale lanes
    for (int i = 1; i <= 4; i++)
      add(1, 0, 4095, 4095, 904, 1513, 0, 0, 0, 0, 0, 0, 0, i, 1);
    add(1, 0, 4095, 4095, 904, 1513, 0, 20475, 20475, 4520, 7565, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 20475, 20475, 4520, 7565, 0, 0, 0, 0);
    // Gapped valid, p1 = 1..5
    add(1, 0, 1, 0, 0, 0, 0, 20475, 20475, 4520, 7565, 0, 0, 1, 1);
    add(1, 0, 2, 0, 0, 0, 0, 20475, 20475, 4520, 7565, 0, 0, 2, 1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 9, 9, 9, 9, 9, 20475, 20475, 4520, 7565, 0, 0, 2, 1);
    add(1, 0, 3, 0, 0, 0, 0, 20475, 20475, 4520, 7565, 0, 0, 3, 1);
    add(1, 0, 4, 0, 0, 0, 0, 20475, 20475, 4520, 7565, 0, 0, 4, 1);
    add(1, 0, 5, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 0);
    // Clear mid-group: three beats of 100, then clear with a valid beat
    for (int i = 1; i <= 3; i++)
      add(1, 0, 100, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, i, 1);
    add(1, 1, 100, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(1, 0, 7, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, i, 1);
    add(1, 0, 7, 0, 0, 0, 0, 35, 0, 0, 0, 0, 1, 0, 0);
    // Back-to-back groups on p3
    for (int i = 1; i <= 4; i++)
      add(1, 0, 0, 0, 10, 0, 0, 35, 0, 0, 0, 0, 0, i, 1);
    add(1, 0, 0, 0, 10, 0, 0, 0, 0, 50, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(1, 0, 0, 0, 20, 0, 0, 0, 0, 50, 0, 0, 0, i, 1);
    add(1, 0, 0, 0, 20, 0, 0, 0, 0, 100, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0);
    // Clear arriving on what would have been the final beat
    for (int i = 1; i <= 4; i++)
      add(1, 0, 0, 1, 0, 0, 0, 0, 0, 100, 0, 0, 0, i, 1);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0);

    // Reset, released away from the clock edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = '{valid:0, clr:0, p:'0, e:'0, sv:0, cnt:0, bsy:0};
    check("reset_state", r);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].valid, tbl[i].clr, tbl[i].p);
      check($sformatf("table_%0d", i), tbl[i]);
    end

    // Async reset mid-group
    pb = '0;
    pb[4] = 12'd9;
    for (int i = 1; i <= 4; i++) step(1, 0, pb);
    #2;
    rst = 1'b1;
    #1;
    r = '{valid:0, clr:0, p:'0, e:'0, sv:0, cnt:0, bsy:0};
    check("async_reset", r);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pb[4] = 12'd2345;
    for (int i = 1; i <= 4; i++) step(1, 0, pb);
    step(1, 0, pb);
    r.e = '0;
    r.e[4] = 16'd11725;
    r.sv = 1'b1;
    check("post_reset_group", r);

    // Hold between groups
    r.sv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, pz);
      check($sformatf("hold_%0d", i), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_entry_wise_accumulator
`default_nettype wire

// File: doc/entry_wise_accumulator.md
Name: entry_wise_accumulator

Overview:
Upstream feeder for the entry-wise mean stage.
- Takes five parallel 12-bit pixel lanes.
- Sums each lane over a group of N_SAMPLES valid beats.
- Presents five 16-bit sums (e1..e5) that the mean stage divides by 5.
- Raises a one-cycle sum_valid strobe when a group completes.
- Accumulators are double-buffered, so a new group starts accumulating while the previous sums stay stable on the outputs.

Parameters:
- DATA_W, 12: width of each input pixel lane.
- SUM_W, 16: width of each output sum. Must be >= DATA_W + ceil(log2(N_SAMPLES)).
- N_SAMPLES, 5: number of valid beats summed per group. Must be >= 2.
- CNT_W, 3: width of the beat counter. Must be >= ceil(log2(N_SAMPLES)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous discard of the partial group.
- in_valid  in  1  p1..p5 carry a valid beat this cycle.
- p1..p5  in  DATA_W each  pixel lanes 1..5.
- e1..e5  out  SUM_W each  registered group sums, lanes 1..5.
- sum_valid  out  1  one-cycle strobe: e1..e5 were updated with a new group.
- beat_cnt  out  CNT_W  beats accepted so far in the current group.
- busy  out  1  high while a partial group is held.

Behaviour:
- Reset: asynchronous, active-high. Every register is cleared:
  - acc1..acc5, e1..e5, beat_cnt = 0
  - sum_valid = 0, busy = 0
  - state = IDLE
- State machine:
  - IDLE: beat_cnt == 0, accumulators are 0.
  - ACCUM: 0 < beat_cnt < N_SAMPLES.
  - busy = (state == ACCUM).
- Accepting a beat:
  - A beat is accepted on any rising edge with in_valid=1 and clear=0.
  - There is no backpressure; every accepted beat is consumed.
- Non-final beat (beat_cnt < N_SAMPLES-1):
  - acc_k <= acc_k + p_k, zero-extended to SUM_W.
  - beat_cnt increments.
  - IDLE moves to ACCUM.
- Final beat (beat_cnt == N_SAMPLES-1):
  - e_k <= acc_k + p_k.
  - acc_k <= 0, beat_cnt <= 0, state returns to IDLE.
  - sum_valid <= 1.
  - Latency: e1..e5 and sum_valid are visible the cycle after the Nth accepted beat.
- sum_valid is high for exactly one cycle per completed group, including back-to-back groups.
- e1..e5 hold their value until the next group completes; they are never changed by clear.
- Gaps (in_valid=0): accumulators and beat_cnt hold; there is no timeout.
- clear=1:
  - acc_k <= 0, beat_cnt <= 0, state returns to IDLE.
  - clear wins over a simultaneous in_valid; that beat is dropped.
  - sum_valid is 0 that cycle, even if the dropped beat would have been final.
- Width rule: acc_k + p_k is computed at SUM_W bits with no saturation. The parameter constraint guarantees no overflow; with the defaults the maximum sum is 5*4095 = 20475.
- Reset mid-group discards the partial group and zeroes e1..e5 immediately, without waiting for a clock edge.
- Simulation-only check: parameter constraints are asserted at time 0, with a $fatal on violation.

Decomposition:
- Shared package cfa_pkg holds:
  - constants PIX_W=12, SUM_W=16, MEAN_GROUP=5
  - a lane-count constant N_LANES=5
  - the state enum {IDLE, ACCUM}
- This block and the mean stage both import cfa_pkg.
- One natural sub-module, lane_accumulator: a single-lane acc/e register pair with load/clear controls, instantiated 5 times.
- The controller (counter and FSM) lives in the top level.

Test Plan:
- Full-scale lanes. Reset, then 5 consecutive beats with p1=4095, p2=4095, p3=904, p4=1513, p5=0.
  - Required: one cycle after the 5th beat, e1=20475, e2=20475, e3=4520, e4=7565, e5=0.
  - sum_valid high for exactly 1 cycle.
- Gapped valid. Beats with p1=1..5 (one value per beat), in_valid idle for 3 cycles between beats 2 and 3.
  - Required: e1=15, and sum_valid only after beat 5.
  - busy=1 from beat 1 to beat 5.
  - beat_cnt reads 1, 2, 2, 2, 2, 3, 4, then 0.
- Clear mid-group. 3 beats of p1=100, then clear with in_valid=1, then 5 beats of p1=7.
  - Required: e1 stays at its previous value after the clear.
  - Then e1=35; the clear-cycle beat is not counted.
- Back-to-back groups. 10 consecutive beats with p3=10 for beats 1-5 and p3=20 for beats 6-10.
  - Required: sum_valid pulses after beat 5 (e3=50) and after beat 10 (e3=100).
  - Exactly 2 pulses total.
- Async reset mid-group. After 4 beats, assert rst between clock edges.
  - Required: all outputs are 0 before the next clk edge.
  - After release, 5 beats of p5=2345 give e5=11725.
- Hold between groups. After a completed group, drive in_valid=0 for 20 cycles.
  - Required: e1..e5 are constant and sum_valid stays 0 throughout.
